data_mem_stage: RTL and testbench

DATA_MEM_STAGE -- requirements
Module: data_mem_stage

---
 rtl/data_mem_stage_pkg.sv | 46 ++++
 rtl/data_mem_stage_load_align.sv | 50 +++++
 rtl/data_mem_stage.sv | 162 ++++++++++++++++
 tb/tb_data_mem_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_stage_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_stage_pkg
//   Shared pipeline definitions for the memory stage: the access-size encoding
//   used by the decoder, the EX/MEM register and the data memory stage, plus
//   small helpers for alignment checks and byte-enable generation.
// -----------------------------------------------------------------------------
package data_mem_stage_pkg;

    // Access size encoding carried down the pipeline.
    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10,
        SIZE_NONE = 2'b11
    } mem_size_e;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STORE_CNT_W = 16;

    // True when an access of the given size cannot start at this byte offset.
    // Byte accesses and no-access are always aligned.
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            SIZE_WORD: mis = (addr_lo != 2'b00);
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Little-endian byte lanes touched by an access.
    function automatic logic [3:0] byte_enables(input mem_size_e size, input logic [1:0] addr_lo);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_WORD: be = 4'b1111;
            SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            SIZE_BYTE: be = 4'b0001 << addr_lo;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/data_mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align
//   Load-path lane selection and extension. Picks the addressed byte or half
//   out of a raw RAM word (little-endian) and sign- or zero-extends it.
//
//   Ports:
//     word_i      raw 32-bit word read from RAM
//     size_i      access size (word/half/byte/none)
//     addr_lo_i   byte offset within the word (AddrIn[1:0])
//     unsigned_i  1 = zero-extend sub-word data, 0 = sign-extend
//     data_o      aligned, extended load data (0 for size NONE)
// -----------------------------------------------------------------------------
module load_align
    import data_mem_stage_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  mem_size_e         size_i,
    input  logic [1:0]        addr_lo_i,
    input  logic              unsigned_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        byte_sel = word_i[7:0];
        half_sel = word_i[15:0];
        data_o   = '0;

        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase

        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        case (size_i)
            SIZE_WORD: data_o = word_i;
            SIZE_HALF: data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
            SIZE_BYTE: data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
            default:   data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_stage.sv
// -----------------------------------------------------------------------------
// data_mem_stage
//   Pipeline memory stage: word-organised data RAM with byte-lane stores,
//   zero-latency loads, misalignment detection, a sticky error capture of the
//   first misaligned address, and a saturating committed-store counter.
//
//   Parameters:
//     MEM_WORDS       RAM depth in 32-bit words (power of two)
//   Ports:
//     Clk             sole clock, rising edge
//     Rst_n           synchronous active-low reset
//     MemReadIn       load request this cycle
//     MemWriteIn      store request this cycle
//     bytes2LoadIn    load size (00 word, 01 half, 10 byte, 11 none)
//     bytes2StoreIn   store size, same encoding
//     LoadUnsignedIn  1 = zero-extend sub-word load, 0 = sign-extend
//     AddrIn          byte address (upper bits beyond the RAM wrap)
//     WriteDataIn     store data, sub-word stores take the low bits
//     LoadDataOut     extended load data, combinational
//     MisalignOut     current request is misaligned, combinational
//     ErrStickyOut    a misaligned access has been seen since reset
//     ErrAddrOut      address of the first misaligned access
//     StoreCountOut   saturating count of committed stores
// -----------------------------------------------------------------------------
module data_mem_stage
    import data_mem_stage_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   MemReadIn,
    input  logic                   MemWriteIn,
    input  logic [1:0]             bytes2LoadIn,
    input  logic [1:0]             bytes2StoreIn,
    input  logic                   LoadUnsignedIn,
    input  logic [31:0]            AddrIn,
    input  logic [31:0]            WriteDataIn,
    output logic [31:0]            LoadDataOut,
    output logic                   MisalignOut,
    output logic                   ErrStickyOut,
    output logic [31:0]            ErrAddrOut,
    output logic [STORE_CNT_W-1:0] StoreCountOut
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    mem_size_e         ld_size;
    mem_size_e         st_size;
    logic [IDX_W-1:0]  word_idx;
    logic              ld_misalign;
    logic              st_misalign;

    assign ld_size  = mem_size_e'(bytes2LoadIn);
    assign st_size  = mem_size_e'(bytes2StoreIn);
    // Upper address bits are dropped, so the address space wraps on the RAM.
    assign word_idx = AddrIn[IDX_W+1:2];

    // Each side only counts as misaligned when its request is actually active.
    assign ld_misalign = MemReadIn  && is_misaligned(ld_size, AddrIn[1:0]);
    assign st_misalign = MemWriteIn && is_misaligned(st_size, AddrIn[1:0]);
    assign MisalignOut = ld_misalign || st_misalign;

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] st_data;
    logic [3:0]        st_be;
    logic              st_commit;

    // Asynchronous read: a store in the same cycle has not yet committed, so a
    // simultaneous load returns the pre-store contents.
    assign rd_word = mem_q[word_idx];

    assign st_commit = Rst_n && MemWriteIn && (st_size != SIZE_NONE) && !st_misalign;
    assign st_be     = byte_enables(st_size, AddrIn[1:0]);

    // Replicate sub-word data across all lanes; the byte enables pick the lane.
    always_comb begin
        st_data = WriteDataIn;
        case (st_size)
            SIZE_HALF: st_data = {2{WriteDataIn[15:0]}};
            SIZE_BYTE: st_data = {4{WriteDataIn[7:0]}};
            default:   st_data = WriteDataIn;
        endcase
    end

    // NOTE: the RAM array has no reset branch; clearing it would turn it into
    // a huge bank of flops. Only the stores themselves are gated by Rst_n.
    always_ff @(posedge Clk) begin
        if (st_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem_q[word_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] aligned_data;

    load_align u_load_align (
        .word_i     (rd_word),
        .size_i     (ld_size),
        .addr_lo_i  (AddrIn[1:0]),
        .unsigned_i (LoadUnsignedIn),
        .data_o     (aligned_data)
    );

    assign LoadDataOut = (MemReadIn && (ld_size != SIZE_NONE) && !ld_misalign)
                         ? aligned_data : '0;

    // ------------------------------------------------------------------
    // Error capture and store counter
    // ------------------------------------------------------------------
    logic                   err_sticky_q, err_sticky_d;
    logic [31:0]            err_addr_q,   err_addr_d;
    logic [STORE_CNT_W-1:0] store_cnt_q,  store_cnt_d;

    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        store_cnt_d  = store_cnt_q;

        // Only the first misalignment after reset is recorded.
        if (MisalignOut && !err_sticky_q) begin
            err_sticky_d = 1'b1;
            err_addr_d   = AddrIn;
        end

        if (st_commit && (store_cnt_q != '1)) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
            store_cnt_q  <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
            store_cnt_q  <= store_cnt_d;
        end
    end

    assign ErrStickyOut  = err_sticky_q;
    assign ErrAddrOut    = err_addr_q;
    assign StoreCountOut = store_cnt_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_data_mem_stage
//   Directed self-checking bench for data_mem_stage with hand-computed
//   expected values. Inputs change 1 ns after a rising edge; combinational
//   outputs are sampled 1 ns later, registered outputs 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_data_mem_stage;
    import data_mem_stage_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        MemReadIn;
    logic        MemWriteIn;
    logic [1:0]  bytes2LoadIn;
    logic [1:0]  bytes2StoreIn;
    logic        LoadUnsignedIn;
    logic [31:0] AddrIn;
    logic [31:0] WriteDataIn;
    logic [31:0] LoadDataOut;
    logic        MisalignOut;
    logic        ErrStickyOut;
    logic [31:0] ErrAddrOut;
    logic [15:0] StoreCountOut;

    int errors = 0;
    int checks = 0;

    data_mem_stage #(.MEM_WORDS(1024)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .MemReadIn      (MemReadIn),
        .MemWriteIn     (MemWriteIn),
        .bytes2LoadIn   (bytes2LoadIn),
        .bytes2StoreIn  (bytes2StoreIn),
        .LoadUnsignedIn (LoadUnsignedIn),
        .AddrIn         (AddrIn),
        .WriteDataIn    (WriteDataIn),
        .LoadDataOut    (LoadDataOut),
        .MisalignOut    (MisalignOut),
        .ErrStickyOut   (ErrStickyOut),
        .ErrAddrOut     (ErrAddrOut),
        .StoreCountOut  (StoreCountOut)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drive one request and let the combinational outputs settle.
    task automatic drive(input logic rd, input logic wr, input logic [1:0] lsz,
                         input logic [1:0] ssz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        MemReadIn      = rd;
        MemWriteIn     = wr;
        bytes2LoadIn   = lsz;
        bytes2StoreIn  = ssz;
        LoadUnsignedIn = uns;
        AddrIn         = addr;
        WriteDataIn    = wdata;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, SIZE_NONE, SIZE_NONE, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        Rst_n = 1'b0;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_sticky", 32'(ErrStickyOut), 32'h0);
        check("rst_addr", ErrAddrOut, 32'h0);
        check("rst_count", 32'(StoreCountOut), 32'h0);
        check("idle_load_zero", LoadDataOut, 32'h0);
        check("idle_misalign", 32'(MisalignOut), 32'h0);

        // Store committed, then a store during reset is suppressed
        Rst_n = 1'b1;
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_WORD, 1'b0, 32'h80, 32'h12345678);
        check("aligned_store_misalign", 32'(MisalignOut), 32'h0);
        tick();
        check("count_after_first", 32'(StoreCountOut), 32'h1);
        Rst_n = 1'b0;
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_WORD, 1'b0, 32'h80, 32'hDEADBEEF);
        tick();
        check("count_in_reset", 32'(StoreCountOut), 32'h0);
        Rst_n = 1'b1;
        drive(1'b1, 1'b0, SIZE_WORD, SIZE_NONE, 1'b0, 32'h80, 32'h0);
        check("store_in_reset_suppressed", LoadDataOut, 32'h12345678);
        tick();

        // Word store, byte loads
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_WORD, 1'b0, 32'h10, 32'h11223344);
        tick();
        drive(1'b1, 1'b0, SIZE_BYTE, SIZE_NONE, 1'b0, 32'h13, 32'h0);
        check("ld_byte_0x13", LoadDataOut, 32'h00000011);
        drive(1'b1, 1'b0, SIZE_BYTE, SIZE_NONE, 1'b0, 32'h10, 32'h0);
        check("ld_byte_0x10", LoadDataOut, 32'h00000044);
        drive(1'b1, 1'b0, SIZE_BYTE, SIZE_NONE, 1'b0, 32'h12, 32'h0);
        check("ld_byte_0x12", LoadDataOut, 32'h00000022);
        drive(1'b0, 1'b0, SIZE_WORD, SIZE_NONE, 1'b0, 32'h10, 32'h0);
        check("no_read_zero", LoadDataOut, 32'h0);

        // Half store into a zero word
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_WORD, 1'b0, 32'h20, 32'h0);
        tick();
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_HALF, 1'b0, 32'h22, 32'h1234BEEF);
        tick();
        drive(1'b1, 1'b0, SIZE_HALF, SIZE_NONE, 1'b0, 32'h22, 32'h0);
        check("ld_half_signed", LoadDataOut, 32'hFFFFBEEF);
        drive(1'b1, 1'b0, SIZE_HALF, SIZE_NONE, 1'b1, 32'h22, 32'h0);
        check("ld_half_unsigned", LoadDataOut, 32'h0000BEEF);
        drive(1'b1, 1'b0, SIZE_WORD, SIZE_NONE, 1'b0, 32'h20, 32'h0);
        check("ld_word_after_half", LoadDataOut, 32'hBEEF0000);
        drive(1'b1, 1'b0, SIZE_HALF, SIZE_NONE, 1'b0, 32'h20, 32'h0);
        check("ld_half_low_kept", LoadDataOut, 32'h0);
        drive(1'b1, 1'b0, SIZE_BYTE, SIZE_NONE, 1'b0, 32'h23, 32'h0);
        check("ld_byte_signed_neg", LoadDataOut, 32'hFFFFFFBE);
        drive(1'b1, 1'b0, SIZE_BYTE, SIZE_NONE, 1'b1, 32'h22, 32'h0);
        check("ld_byte_unsigned", LoadDataOut, 32'h000000EF);

        // Size NONE: load returns 0, store does nothing
        drive(1'b1, 1'b0, SIZE_NONE, SIZE_NONE, 1'b0, 32'h10, 32'h0);
        check("ld_none_zero", LoadDataOut, 32'h0);
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_NONE, 1'b0, 32'h10, 32'hFFFFFFFF);
        tick();
        drive(1'b1, 1'b0, SIZE_WORD, SIZE_NONE, 1'b0, 32'h10, 32'h0);
        check("st_none_no_write", LoadDataOut, 32'h11223344);
        check("count_after_none", 32'(StoreCountOut), 32'h3);

        // Misaligned store, sticky error capture
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_WORD, 1'b0, 32'h04, 32'h0BADC0DE);
        tick();
        check("sticky_before", 32'(ErrStickyOut), 32'h0);
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_WORD, 1'b0, 32'h06, 32'hCAFEF00D);
        check("mis_store_flag", 32'(MisalignOut), 32'h1);
        tick();
        check("mis_sticky_set", 32'(ErrStickyOut), 32'h1);
        check("mis_addr_captured", ErrAddrOut, 32'h06);
        check("mis_store_no_count", 32'(StoreCountOut), 32'h4);
        drive(1'b1, 1'b0, SIZE_WORD, SIZE_NONE, 1'b0, 32'h04, 32'h0);
        check("mis_store_ram_kept", LoadDataOut, 32'h0BADC0DE);
        drive(1'b1, 1'b0, SIZE_WORD, SIZE_NONE, 1'b0, 32'h09, 32'h0);
        check("mis_load_flag", 32'(MisalignOut), 32'h1);
        check("mis_load_zero", LoadDataOut, 32'h0);
        tick();
        check("mis_addr_held", ErrAddrOut, 32'h06);
        drive(1'b1, 1'b0, SIZE_HALF, SIZE_NONE, 1'b0, 32'h11, 32'h0);
        check("mis_half_flag", 32'(MisalignOut), 32'h1);
        check("mis_half_zero", LoadDataOut, 32'h0);
        // Byte load at an odd address; inactive store side must not flag
        drive(1'b1, 1'b0, SIZE_BYTE, SIZE_WORD, 1'b0, 32'h11, 32'h0);
        check("byte_never_mis", 32'(MisalignOut), 32'h0);
        check("ld_byte_0x11", LoadDataOut, 32'h00000033);

        // Simultaneous read and write at the same word
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_WORD, 1'b0, 32'h40, 32'hAAAAAAAA);
        tick();
        drive(1'b1, 1'b1, SIZE_WORD, SIZE_WORD, 1'b0, 32'h40, 32'h55555555);
        check("rw_old_data", LoadDataOut, 32'hAAAAAAAA);
        tick();
        drive(1'b1, 1'b0, SIZE_WORD, SIZE_NONE, 1'b0, 32'h40, 32'h0);
        check("rw_new_data", LoadDataOut, 32'h55555555);

        // Address wrap
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_WORD, 1'b0, 32'h1004, 32'h5A5AA5A5);
        tick();
        drive(1'b1, 1'b0, SIZE_WORD, SIZE_NONE, 1'b0, 32'h0004, 32'h0);
        check("wrap_load", LoadDataOut, 32'h5A5AA5A5);
        check("count_after_wrap", 32'(StoreCountOut), 32'h7);

        // Byte store into lane 1
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_BYTE, 1'b0, 32'h41, 32'hFFFFFF80);
        tick();
        drive(1'b1, 1'b0, SIZE_WORD, SIZE_NONE, 1'b0, 32'h40, 32'h0);
        check("byte_store_lanes", LoadDataOut, 32'h55558055);
        drive(1'b1, 1'b0, SIZE_BYTE, SIZE_NONE, 1'b0, 32'h41, 32'h0);
        check("byte_store_readback", LoadDataOut, 32'hFFFFFF80);
        check("count_before_sat", 32'(StoreCountOut), 32'h8);

        // Saturation: 65527 more stores brings the count to 0xFFFF
        drive(1'b0, 1'b1, SIZE_NONE, SIZE_BYTE, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 65527; i++) begin
            tick();
        end
        check("count_saturated", 32'(StoreCountOut), 32'hFFFF);
        tick();
        check("count_holds", 32'(StoreCountOut), 32'hFFFF);

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
